// File: rtl/bus_dev_fifo_bank.sv
// Bank of per-device TX/RX FIFO pairs acting as the devices around a bus arbiter,
// with sticky overflow/underflow/misroute flags and per-FIFO occupancy.

module bus_dev_fifo #(
  parameter int unsigned PCKG_SZ = 16,
  parameter int unsigned DEPTH   = 8,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr,
  input  logic [PCKG_SZ-1:0] i_wdata,
  input  logic               i_rd,
  output logic [PCKG_SZ-1:0] o_head_c,
  output logic [CW-1:0]      o_cnt,
  output logic               o_full_c,
  output logic               o_nempty_c,
  output logic               o_ovf_c,
  output logic               o_udf_c
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PCKG_SZ-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_cnt;
  logic               w_empty;
  logic               w_full;
  logic               w_do_rd;
  logic               w_do_wr;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_do_rd = i_rd && !w_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign w_do_wr = i_wr && (!w_full || w_do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_wr && !w_do_rd) r_cnt <= r_cnt + CW'(1);
      else if (!w_do_wr && w_do_rd) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head_c   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_cnt      = r_cnt;
  assign o_full_c   = w_full;
  assign o_nempty_c = !w_empty;
  assign o_ovf_c    = i_wr && !w_do_wr;
  assign o_udf_c    = i_rd && w_empty;
endmodule

module bus_dev_fifo_bank #(
  parameter int unsigned     DRVRS     = 6,
  parameter int unsigned     PCKG_SZ   = 16,
  parameter int unsigned     DEPTH     = 8,
  parameter int unsigned     ID_W      = 8,
  parameter logic [ID_W-1:0] BROADCAST = ID_W'('hFF),
  localparam int unsigned    CW        = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         tb_wr,
  input  logic [DRVRS*PCKG_SZ-1:0] tb_wdata,
  output logic [DRVRS-1:0]         tb_full,
  output logic [DRVRS-1:0]         pndng,
  output logic [DRVRS*PCKG_SZ-1:0] D_pop,
  input  logic [DRVRS-1:0]         pop,
  input  logic [DRVRS-1:0]         push,
  input  logic [DRVRS*PCKG_SZ-1:0] D_push,
  input  logic [DRVRS-1:0]         tb_rd,
  output logic [DRVRS-1:0]         tb_rvalid,
  output logic [DRVRS*PCKG_SZ-1:0] tb_rdata,
  output logic [DRVRS*CW-1:0]      tx_cnt,
  output logic [DRVRS*CW-1:0]      rx_cnt,
  input  logic                     err_clr,
  output logic [DRVRS-1:0]         tx_ovf,
  output logic [DRVRS-1:0]         tx_udf,
  output logic [DRVRS-1:0]         rx_ovf,
  output logic [DRVRS-1:0]         misroute
);
  logic [DRVRS-1:0] w_tx_ovf;
  logic [DRVRS-1:0] w_tx_udf;
  logic [DRVRS-1:0] w_rx_ovf;
  logic [DRVRS-1:0] w_misroute;
  logic [DRVRS-1:0] r_tx_ovf;
  logic [DRVRS-1:0] r_tx_udf;
  logic [DRVRS-1:0] r_rx_ovf;
  logic [DRVRS-1:0] r_misroute;

  for (genvar g = 0; g < DRVRS; g++) begin : g_dev
    logic [ID_W-1:0] w_dest;
    logic            w_rx_udf_unused;

    bus_dev_fifo #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
      .clk        (clk),
      .reset      (reset),
      .i_wr       (tb_wr[g]),
      .i_wdata    (tb_wdata[g*PCKG_SZ +: PCKG_SZ]),
      .i_rd       (pop[g]),
      .o_head_c   (D_pop[g*PCKG_SZ +: PCKG_SZ]),
      .o_cnt      (tx_cnt[g*CW +: CW]),
      .o_full_c   (tb_full[g]),
      .o_nempty_c (pndng[g]),
      .o_ovf_c    (w_tx_ovf[g]),
      .o_udf_c    (w_tx_udf[g])
    );

    // tb_rd on an empty RX FIFO is a silent no-op, so its underflow is dropped
    bus_dev_fifo #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .i_wr       (push[g]),
      .i_wdata    (D_push[g*PCKG_SZ +: PCKG_SZ]),
      .i_rd       (tb_rd[g]),
      .o_head_c   (tb_rdata[g*PCKG_SZ +: PCKG_SZ]),
      .o_cnt      (rx_cnt[g*CW +: CW]),
      .o_full_c   (),
      .o_nempty_c (tb_rvalid[g]),
      .o_ovf_c    (w_rx_ovf[g]),
      .o_udf_c    (w_rx_udf_unused)
    );

    assign w_dest        = D_push[g*PCKG_SZ + PCKG_SZ - 1 -: ID_W];
    assign w_misroute[g] = push[g] && (w_dest != ID_W'(g)) && (w_dest != BROADCAST);
  end

  // Sticky error flags; err_clr wins over a same-cycle event
  always_ff @(posedge clk) begin
    if (reset || err_clr) begin
      r_tx_ovf   <= '0;
      r_tx_udf   <= '0;
      r_rx_ovf   <= '0;
      r_misroute <= '0;
    end else begin
      r_tx_ovf   <= r_tx_ovf   | w_tx_ovf;
      r_tx_udf   <= r_tx_udf   | w_tx_udf;
      r_rx_ovf   <= r_rx_ovf   | w_rx_ovf;
      r_misroute <= r_misroute | w_misroute;
    end
  end

  assign tx_ovf   = r_tx_ovf;
  assign tx_udf   = r_tx_udf;
  assign rx_ovf   = r_rx_ovf;
  assign misroute = r_misroute;
endmodule

// File: tb/tb_bus_dev_fifo_bank.sv
// Scoreboard bench for bus_dev_fifo_bank: stimulus pushes expected words, a negedge
// monitor pops them as the DUT hands words out; a small model tracks counts and flags.

module tb_bus_dev_fifo_bank;
  localparam int N  = 6;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   tb_wr, pop, push, tb_rd;
  logic [N*W-1:0] tb_wdata, D_push;
  logic           err_clr;
  logic [N-1:0]   tb_full, pndng, tb_rvalid, tx_ovf, tx_udf, rx_ovf, misroute;
  logic [N*W-1:0] D_pop, tb_rdata;
  logic [N*CW-1:0] tx_cnt, rx_cnt;

  bus_dev_fifo_bank dut (
    .clk(clk), .reset(reset), .tb_wr(tb_wr), .tb_wdata(tb_wdata), .tb_full(tb_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .tb_rd(tb_rd), .tb_rvalid(tb_rvalid), .tb_rdata(tb_rdata), .tx_cnt(tx_cnt),
    .rx_cnt(rx_cnt), .err_clr(err_clr), .tx_ovf(tx_ovf), .tx_udf(tx_udf),
    .rx_ovf(rx_ovf), .misroute(misroute)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   dev;
    logic [W-1:0] d;
  } ent_t;

  ent_t txq[$];
  ent_t rxq[$];
  int   tx_n[N];
  int   rx_n[N];
  logic [N-1:0] m_txovf, m_udf, m_rxovf, m_mis;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] tx_head(input int i);
    foreach (txq[j]) if (txq[j].dev == 8'(i)) return txq[j].d;
    return '0;
  endfunction

  function automatic logic [W-1:0] rx_head(input int i);
    foreach (rxq[j]) if (rxq[j].dev == 8'(i)) return rxq[j].d;
    return '0;
  endfunction

  task automatic take_tx(input int i, input logic [W-1:0] act);
    int k = -1;
    foreach (txq[j]) if (k < 0 && txq[j].dev == 8'(i)) k = j;
    if (k < 0) chk($sformatf("tx_pop_unexpected_dev%0d", i), 1, 0);
    else begin
      chk($sformatf("tx_pop_data_dev%0d", i), act, txq[k].d);
      txq.delete(k);
    end
  endtask

  task automatic take_rx(input int i, input logic [W-1:0] act);
    int k = -1;
    foreach (rxq[j]) if (k < 0 && rxq[j].dev == 8'(i)) k = j;
    if (k < 0) chk($sformatf("rx_rd_unexpected_dev%0d", i), 1, 0);
    else begin
      chk($sformatf("rx_rd_data_dev%0d", i), act, rxq[k].d);
      rxq.delete(k);
    end
  endtask

  // Monitor: whenever a word is handed out, compare it to the scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset === 1'b0 && pop[i] && pndng[i] === 1'b1) take_tx(i, D_pop[i*W +: W]);
      if (reset === 1'b0 && tb_rd[i] && tb_rvalid[i] === 1'b1) take_rx(i, tb_rdata[i*W +: W]);
    end
  end

  task automatic verify();
    logic [N-1:0]    e_pn, e_full, e_rv;
    logic [N*CW-1:0] e_txc, e_rxc;
    logic [N*W-1:0]  e_dp, e_rd;
    for (int i = 0; i < N; i++) begin
      e_pn[i]           = (tx_n[i] != 0);
      e_full[i]         = (tx_n[i] == D);
      e_rv[i]           = (rx_n[i] != 0);
      e_txc[i*CW +: CW] = CW'(tx_n[i]);
      e_rxc[i*CW +: CW] = CW'(rx_n[i]);
      e_dp[i*W +: W]    = tx_head(i);
      e_rd[i*W +: W]    = rx_head(i);
    end
    chk("pndng", pndng, e_pn);
    chk("tb_full", tb_full, e_full);
    chk("tb_rvalid", tb_rvalid, e_rv);
    chk("tx_cnt", tx_cnt, e_txc);
    chk("rx_cnt", rx_cnt, e_rxc);
    chk("D_pop", D_pop, e_dp);
    chk("tb_rdata", tb_rdata, e_rd);
    chk("tx_ovf", tx_ovf, m_txovf);
    chk("tx_udf", tx_udf, m_udf);
    chk("rx_ovf", rx_ovf, m_rxovf);
    chk("misroute", misroute, m_mis);
  endtask

  // Update the model from the strobes about to be clocked, clock, clear strobes, check
  task automatic tick();
    logic [N-1:0] ev_to, ev_u, ev_ro, ev_m;
    ev_to = '0; ev_u = '0; ev_ro = '0; ev_m = '0;
    if (reset) begin
      txq.delete(); rxq.delete();
      for (int i = 0; i < N; i++) begin tx_n[i] = 0; rx_n[i] = 0; end
      m_txovf = '0; m_udf = '0; m_rxovf = '0; m_mis = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bit rd, wr;
        logic [7:0] dst;
        rd = pop[i] && tx_n[i] > 0;
        wr = tb_wr[i] && (tx_n[i] < D || rd);
        if (wr) txq.push_back('{dev: 8'(i), d: tb_wdata[i*W +: W]});
        ev_to[i] = tb_wr[i] && !wr;
        ev_u[i]  = pop[i] && tx_n[i] == 0;
        tx_n[i]  = tx_n[i] + int'(wr) - int'(rd);
        rd = tb_rd[i] && rx_n[i] > 0;
        wr = push[i] && (rx_n[i] < D || rd);
        if (wr) rxq.push_back('{dev: 8'(i), d: D_push[i*W +: W]});
        ev_ro[i] = push[i] && !wr;
        dst      = D_push[i*W + 8 +: 8];
        ev_m[i]  = push[i] && dst != 8'(i) && dst != 8'hFF;
        rx_n[i]  = rx_n[i] + int'(wr) - int'(rd);
      end
      if (err_clr) begin
        m_txovf = '0; m_udf = '0; m_rxovf = '0; m_mis = '0;
      end else begin
        m_txovf |= ev_to; m_udf |= ev_u; m_rxovf |= ev_ro; m_mis |= ev_m;
      end
    end
    @(posedge clk);
    #1;
    tb_wr = '0; pop = '0; push = '0; tb_rd = '0; err_clr = 1'b0; reset = 1'b0;
    verify();
  endtask

  task automatic wr_tx(input int i, input logic [W-1:0] d);
    tb_wr[i] = 1'b1;
    tb_wdata[i*W +: W] = d;
  endtask

  task automatic wr_rx(input int i, input logic [W-1:0] d);
    push[i] = 1'b1;
    D_push[i*W +: W] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; err_clr = 1'b0;
    tb_wr = '0; pop = '0; push = '0; tb_rd = '0; tb_wdata = '0; D_push = '0;
    m_txovf = '0; m_udf = '0; m_rxovf = '0; m_mis = '0;
    for (int i = 0; i < N; i++) begin tx_n[i] = 0; rx_n[i] = 0; end
    @(negedge clk);

    // 1. reset
    reset = 1'b1; tick();
    chk("rst_dpop", D_pop, 0);
    chk("rst_txcnt", tx_cnt, 0);

    // 2. two writes, fall-through, drain
    wr_tx(2, 16'h0312); tick();
    chk("t2_head0", D_pop[2*W +: W], 16'h0312);
    wr_tx(2, 16'h0555); tick();
    pop[2] = 1'b1; tick();
    chk("t2_head1", D_pop[2*W +: W], 16'h0555);
    pop[2] = 1'b1; tick();
    chk("t2_pndng", pndng[2], 1'b0);
    chk("t2_dpop0", D_pop[2*W +: W], 16'h0000);

    // 3. overflow TX0, then write+pop while full
    for (int k = 0; k < 9; k++) begin wr_tx(0, W'(16'h0A00 + k)); tick(); end
    chk("t3_full", tb_full[0], 1'b1);
    chk("t3_cnt", tx_cnt[0 +: CW], 4'd8);
    chk("t3_ovf", tx_ovf[0], 1'b1);
    err_clr = 1'b1; tick();
    chk("t3_ovf_clr", tx_ovf[0], 1'b0);
    wr_tx(0, 16'h0B00); pop[0] = 1'b1; tick();
    chk("t3_cnt_full_rw", tx_cnt[0 +: CW], 4'd8);
    chk("t3_no_new_ovf", tx_ovf[0], 1'b0);
    chk("t3_head", D_pop[0 +: W], 16'h0A01);
    repeat (8) begin pop[0] = 1'b1; tick(); end
    chk("t3_empty", pndng[0], 1'b0);

    // 4. destination check on RX4
    wr_rx(4, 16'hFF7A); tick();
    wr_rx(4, 16'h047A); tick();
    chk("t4_mis_ok", misroute[4], 1'b0);
    wr_rx(4, 16'h017A); tick();
    chk("t4_mis_set", misroute[4], 1'b1);
    chk("t4_rxcnt", rx_cnt[4*CW +: CW], 4'd3);
    chk("t4_head", tb_rdata[4*W +: W], 16'hFF7A);
    repeat (3) begin tb_rd[4] = 1'b1; tick(); end
    tb_rd[4] = 1'b1; tick();
    chk("t4_rd_empty_noop", rx_cnt[4*CW +: CW], 4'd0);

    // RX overflow on device 5, then push+read while full
    for (int k = 0; k < 9; k++) begin wr_rx(5, W'(16'h0500 + k)); tick(); end
    chk("rx_ovf_set", rx_ovf[5], 1'b1);
    wr_rx(5, 16'h05AA); tb_rd[5] = 1'b1; tick();
    chk("rx_full_rw_cnt", rx_cnt[5*CW +: CW], 4'd8);
    repeat (8) begin tb_rd[5] = 1'b1; tick(); end

    // 5. underflow and err_clr priority
    err_clr = 1'b1; tick();
    pop[1] = 1'b1; tick();
    chk("t5_udf", tx_udf[1], 1'b1);
    err_clr = 1'b1; tick();
    chk("t5_udf_clr", tx_udf[1], 1'b0);
    err_clr = 1'b1; pop[1] = 1'b1; tick();
    chk("t5_clr_wins", tx_udf[1], 1'b0);
    wr_tx(1, 16'h0111); pop[1] = 1'b1; tick();
    chk("t5_empty_rw_cnt", tx_cnt[1*CW +: CW], 4'd1);
    chk("t5_empty_rw_udf", tx_udf[1], 1'b1);
    pop[1] = 1'b1; tick();

    // 6. reset mid-operation
    for (int k = 0; k < 5; k++) begin wr_tx(3, W'(16'h0300 + k)); tick(); end
    chk("t6_cnt5", tx_cnt[3*CW +: CW], 4'd5);
    reset = 1'b1; tick();
    chk("t6_pndng", pndng[3], 1'b0);
    chk("t6_cnt0", tx_cnt[3*CW +: CW], 4'd0);
    wr_tx(3, 16'h0C33); tick();
    chk("t6_fresh", D_pop[3*W +: W], 16'h0C33);
    pop[3] = 1'b1; tick();

    chk("scoreboard_empty", 128'(txq.size() + rxq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
